// File: rtl/mem_resp.sv
// rtl/mem_resp.sv - wait-state word memory responder for a multicycle CPU datapath
// Captures one request, waits WAIT_CYC cycles, pulses MemRdy, then holds until the request drops.
module mem_resp #(
  parameter int ADDR_W   = 8,
  parameter int WAIT_CYC = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRd,
  input  logic        MemWr,
  input  logic [31:0] Addr,
  input  logic [31:0] WrData,
  output logic [31:0] RdData,
  output logic        MemRdy,
  output logic        MemErr,
  output logic        Busy
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = (WAIT_CYC > 0) ? 4'(WAIT_CYC - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP,
    S_HOLD
  } state_t;

  state_t              state_q;
  logic [3:0]          cnt_q;
  logic [ADDR_W-1:0]   idx_q;
  logic [31:0]         wdata_q;
  logic                wr_q;
  logic                err_q;
  logic [31:0]         rdata_q;
  logic                rdy_q;
  logic                merr_q;
  logic                busy_q;
  logic [31:0]         mem_q [DEPTH];

  logic                req_d;
  logic                err_d;
  logic                go_resp_d;
  logic [ADDR_W-1:0]   acc_idx_d;
  logic [31:0]         acc_wdata_d;
  logic                acc_wr_d;
  logic                acc_err_d;

  assign req_d = MemRd | MemWr;
  assign err_d = (Addr[1:0] != 2'b00) ||
                 ((Addr >> (ADDR_W + 2)) != 32'd0) ||
                 (MemRd && MemWr);

  // The access happens on the edge entering RESP so RdData is valid alongside MemRdy.
  // With no wait cycles that edge is the capture edge, so operands come straight from the inputs.
  assign go_resp_d = ((state_q == S_IDLE) && req_d && (WAIT_CYC == 0)) ||
                     ((state_q == S_WAIT) && (cnt_q == 4'd0));

  always_comb begin
    acc_idx_d   = idx_q;
    acc_wdata_d = wdata_q;
    acc_wr_d    = wr_q;
    acc_err_d   = err_q;
    if (state_q == S_IDLE) begin
      acc_idx_d   = Addr[ADDR_W+1:2];
      acc_wdata_d = WrData;
      acc_wr_d    = MemWr;
      acc_err_d   = err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (go_resp_d && acc_wr_d && !acc_err_d) begin
      mem_q[acc_idx_d] <= acc_wdata_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= '0;
      wdata_q <= 32'd0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= 32'd0;
      rdy_q   <= 1'b0;
      merr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      rdy_q  <= 1'b0;
      merr_q <= 1'b0;
      if (go_resp_d) begin
        rdy_q  <= 1'b1;
        merr_q <= acc_err_d;
        if (!acc_wr_d && !acc_err_d) begin
          rdata_q <= mem_q[acc_idx_d];
        end
      end
      case (state_q)
        S_IDLE: begin
          if (req_d) begin
            idx_q   <= Addr[ADDR_W+1:2];
            wdata_q <= WrData;
            wr_q    <= MemWr;
            err_q   <= err_d;
            cnt_q   <= CNT_INIT;
            busy_q  <= 1'b1;
            state_q <= (WAIT_CYC > 0) ? S_WAIT : S_RESP;
          end
        end
        S_WAIT: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          busy_q  <= 1'b0;
          state_q <= S_HOLD;
        end
        S_HOLD: begin
          // A request still held from the last access must drop before another is taken.
          if (!req_d) begin
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign RdData = rdata_q;
  assign MemRdy = rdy_q;
  assign MemErr = merr_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_mem_resp.sv
// tb/tb_mem_resp.sv - randomized self-checking bench for mem_resp (WAIT_CYC=2 and WAIT_CYC=0 builds)
module tb_mem_resp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        rd2, wr2, rd0, wr0;
  logic [31:0] a2, w2, a0, w0;
  logic [31:0] rdata2, rdata0;
  logic        rdy2, err2, busy2, rdy0, err0, busy0;

  mem_resp #(.ADDR_W(8), .WAIT_CYC(2)) u_d2 (
    .clk(clk), .rst_n(rst_n), .MemRd(rd2), .MemWr(wr2), .Addr(a2), .WrData(w2),
    .RdData(rdata2), .MemRdy(rdy2), .MemErr(err2), .Busy(busy2)
  );

  mem_resp #(.ADDR_W(8), .WAIT_CYC(0)) u_d0 (
    .clk(clk), .rst_n(rst_n), .MemRd(rd0), .MemWr(wr0), .Addr(a0), .WrData(w0),
    .RdData(rdata0), .MemRdy(rdy0), .MemErr(err0), .Busy(busy0)
  );

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] mem2_m [int];
  logic [31:0] mem0_m [int];
  logic [31:0] rd_m [2];

  function automatic bit exp_err(input bit rd, input bit wr, input logic [31:0] a);
    return (a % 4 != 0) || (a >= 32'd1024) || (rd && wr);
  endfunction

  task automatic model_apply(input int sel, input bit rd, input bit wr, input logic [31:0] a,
                             input logic [31:0] d, output bit e, output logic [31:0] rdx);
    int idx;
    idx = int'(a / 4);
    e = exp_err(rd, wr, a);
    if (!e) begin
      if (wr) begin
        if (sel == 0) mem0_m[idx] = d; else mem2_m[idx] = d;
      end else begin
        if (sel == 0) rd_m[0] = mem0_m.exists(idx) ? mem0_m[idx] : 32'h0;
        else          rd_m[1] = mem2_m.exists(idx) ? mem2_m[idx] : 32'h0;
      end
    end
    rdx = rd_m[sel == 0 ? 0 : 1];
  endtask

  task automatic drive(input int sel, input bit rd, input bit wr, input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin rd0 = rd; wr0 = wr; a0 = a; w0 = d; end
    else          begin rd2 = rd; wr2 = wr; a2 = a; w2 = d; end
  endtask

  // Drives one request (called just after a falling edge) and records what the DUT did.
  task automatic run_req(input int sel, input bit rd, input bit wr, input logic [31:0] a,
                         input logic [31:0] d, input int hold, output int pulses, output int lat,
                         output logic [31:0] rdv, output bit ev, output bit bsy);
    pulses = 0; lat = -1; rdv = 32'h0; ev = 1'b0; bsy = 1'b0;
    drive(sel, rd, wr, a, d);
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (c == 1) bsy = (sel == 0) ? busy0 : busy2;
      if (c >= hold) drive(sel, 1'b0, 1'b0, $urandom, $urandom);
      else           drive(sel, rd, wr, $urandom, $urandom);
      if ((sel == 0) ? rdy0 : rdy2) begin
        pulses++;
        if (lat < 0) begin
          lat = c;
          rdv = (sel == 0) ? rdata0 : rdata2;
          ev  = (sel == 0) ? err0 : err2;
        end
      end
    end
  endtask

  task automatic test_reset;
    #1;
    vectors++; if (rdata2 !== 32'h0) begin miscompares++; $display("FAIL reset_rdata2: got %h expected %h", rdata2, 32'h0); end
    vectors++; if (rdy2 !== 1'b0)    begin miscompares++; $display("FAIL reset_rdy2: got %b expected 0", rdy2); end
    vectors++; if (err2 !== 1'b0)    begin miscompares++; $display("FAIL reset_err2: got %b expected 0", err2); end
    vectors++; if (busy2 !== 1'b0)   begin miscompares++; $display("FAIL reset_busy2: got %b expected 0", busy2); end
    vectors++; if (rdata0 !== 32'h0) begin miscompares++; $display("FAIL reset_rdata0: got %h expected %h", rdata0, 32'h0); end
    vectors++; if (rdy0 !== 1'b0)    begin miscompares++; $display("FAIL reset_rdy0: got %b expected 0", rdy0); end
    vectors++; if (busy0 !== 1'b0)   begin miscompares++; $display("FAIL reset_busy0: got %b expected 0", busy0); end
  endtask

  task automatic test_write_read;
    int p, l; logic [31:0] r, er_rd; bit e, ee, b;
    run_req(2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, 5, p, l, r, e, b);
    model_apply(2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, ee, er_rd);
    vectors++; if (p !== 1) begin miscompares++; $display("FAIL wr_pulses: got %0d expected 1", p); end
    vectors++; if (l !== 3) begin miscompares++; $display("FAIL wr_latency: got %0d expected 3", l); end
    vectors++; if (b !== 1'b1) begin miscompares++; $display("FAIL wr_busy: got %b expected 1", b); end
    run_req(2, 1'b1, 1'b0, 32'h10, 32'h0, 5, p, l, r, e, b);
    model_apply(2, 1'b1, 1'b0, 32'h10, 32'h0, ee, er_rd);
    vectors++; if (r !== er_rd) begin miscompares++; $display("FAIL rd_data: got %h expected %h", r, er_rd); end
    vectors++; if (e !== ee) begin miscompares++; $display("FAIL rd_err: got %b expected %b", e, ee); end
    vectors++; if (l !== 3) begin miscompares++; $display("FAIL rd_latency: got %0d expected 3", l); end
  endtask

  task automatic test_misaligned;
    int p, l; logic [31:0] r, er_rd; bit e, ee, b;
    run_req(2, 1'b1, 1'b0, 32'h13, 32'h0, 2, p, l, r, e, b);
    model_apply(2, 1'b1, 1'b0, 32'h13, 32'h0, ee, er_rd);
    vectors++; if (p !== 1) begin miscompares++; $display("FAIL mis_pulses: got %0d expected 1", p); end
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL mis_err: got %b expected 1", e); end
    vectors++; if (r !== er_rd) begin miscompares++; $display("FAIL mis_rdata: got %h expected %h", r, er_rd); end
  endtask

  task automatic test_held;
    int p, l; logic [31:0] r, er_rd; bit e, ee, b;
    for (int k = 0; k < 2; k++) begin
      run_req(2, 1'b1, 1'b0, 32'h10, 32'h0, 10, p, l, r, e, b);
      model_apply(2, 1'b1, 1'b0, 32'h10, 32'h0, ee, er_rd);
      vectors++; if (p !== 1) begin miscompares++; $display("FAIL held_pulses%0d: got %0d expected 1", k, p); end
      vectors++; if (r !== er_rd) begin miscompares++; $display("FAIL held_rdata%0d: got %h expected %h", k, r, er_rd); end
    end
  endtask

  task automatic test_drop;
    int p, l; logic [31:0] r, er_rd, d; bit e, ee, b;
    d = $urandom;
    run_req(2, 1'b0, 1'b1, 32'h20, d, 1, p, l, r, e, b);
    model_apply(2, 1'b0, 1'b1, 32'h20, d, ee, er_rd);
    vectors++; if (p !== 1) begin miscompares++; $display("FAIL drop_pulses: got %0d expected 1", p); end
    vectors++; if (l !== 3) begin miscompares++; $display("FAIL drop_latency: got %0d expected 3", l); end
    run_req(2, 1'b1, 1'b0, 32'h20, 32'h0, 1, p, l, r, e, b);
    model_apply(2, 1'b1, 1'b0, 32'h20, 32'h0, ee, er_rd);
    vectors++; if (r !== er_rd) begin miscompares++; $display("FAIL drop_readback: got %h expected %h", r, er_rd); end
  endtask

  task automatic test_reset_mid_wait;
    int p, l, seen; logic [31:0] r, er_rd, pre; bit e, ee, b;
    pre = $urandom;
    run_req(2, 1'b0, 1'b1, 32'h30, pre, 2, p, l, r, e, b);
    model_apply(2, 1'b0, 1'b1, 32'h30, pre, ee, er_rd);
    drive(2, 1'b0, 1'b1, 32'h30, ~pre);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    rd_m[0] = 32'h0; rd_m[1] = 32'h0;
    #1;
    vectors++; if (busy2 !== 1'b0) begin miscompares++; $display("FAIL rst_busy: got %b expected 0", busy2); end
    seen = 0;
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (rdy2) seen++; end
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (rdy2) seen++; end
    vectors++; if (seen !== 0) begin miscompares++; $display("FAIL rst_no_rdy: got %0d pulses expected 0", seen); end
    vectors++; if (rdata2 !== 32'h0) begin miscompares++; $display("FAIL rst_rdata: got %h expected %h", rdata2, 32'h0); end
    run_req(2, 1'b1, 1'b0, 32'h30, 32'h0, 3, p, l, r, e, b);
    model_apply(2, 1'b1, 1'b0, 32'h30, 32'h0, ee, er_rd);
    vectors++; if (r !== er_rd) begin miscompares++; $display("FAIL rst_preload: got %h expected %h", r, er_rd); end
  endtask

  task automatic test_random;
    int p, l; logic [31:0] r, er_rd, a, d; bit e, ee, b, rd, wr;
    int kind, hold;
    for (int w = 0; w < 16; w++) begin
      d = $urandom;
      run_req(2, 1'b0, 1'b1, 32'(w * 4), d, 1, p, l, r, e, b);
      model_apply(2, 1'b0, 1'b1, 32'(w * 4), d, ee, er_rd);
    end
    for (int k = 0; k < 40; k++) begin
      a = 32'($urandom_range(0, 15) * 4);
      d = $urandom;
      kind = $urandom_range(0, 9);
      rd = $urandom_range(0, 1); wr = !rd;
      if (kind == 0) a = a | 32'($urandom_range(1, 3));
      if (kind == 1) a = a | (32'h400 << $urandom_range(0, 21));
      if (kind == 2) begin rd = 1'b1; wr = 1'b1; end
      hold = $urandom_range(1, 6);
      run_req(2, rd, wr, a, d, hold, p, l, r, e, b);
      model_apply(2, rd, wr, a, d, ee, er_rd);
      vectors++;
      if (p !== 1 || l !== 3 || e !== ee || r !== er_rd) begin
        miscompares++;
        $display("FAIL rand%0d a=%h rd=%b wr=%b: got pulses=%0d lat=%0d err=%b data=%h expected 1/3/%b/%h",
                 k, a, rd, wr, p, l, e, r, ee, er_rd);
      end
    end
  endtask

  task automatic test_wait0;
    int p, l; logic [31:0] r, er_rd, d; bit e, ee, b;
    d = $urandom;
    run_req(0, 1'b0, 1'b1, 32'h40, d, 1, p, l, r, e, b);
    model_apply(0, 1'b0, 1'b1, 32'h40, d, ee, er_rd);
    vectors++; if (l !== 1) begin miscompares++; $display("FAIL w0_wr_latency: got %0d expected 1", l); end
    run_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 4, p, l, r, e, b);
    model_apply(0, 1'b1, 1'b0, 32'h40, 32'h0, ee, er_rd);
    vectors++; if (l !== 1) begin miscompares++; $display("FAIL w0_rd_latency: got %0d expected 1", l); end
    vectors++; if (p !== 1) begin miscompares++; $display("FAIL w0_rd_pulses: got %0d expected 1", p); end
    vectors++; if (r !== er_rd) begin miscompares++; $display("FAIL w0_rd_data: got %h expected %h", r, er_rd); end
    run_req(0, 1'b1, 1'b1, 32'h40, ~d, 1, p, l, r, e, b);
    model_apply(0, 1'b1, 1'b1, 32'h40, ~d, ee, er_rd);
    vectors++; if (e !== 1'b1) begin miscompares++; $display("FAIL w0_both_err: got %b expected 1", e); end
    vectors++; if (r !== er_rd) begin miscompares++; $display("FAIL w0_both_rdata: got %h expected %h", r, er_rd); end
    run_req(0, 1'b1, 1'b0, 32'h40, 32'h0, 1, p, l, r, e, b);
    model_apply(0, 1'b1, 1'b0, 32'h40, 32'h0, ee, er_rd);
    vectors++; if (r !== er_rd) begin miscompares++; $display("FAIL w0_unchanged: got %h expected %h", r, er_rd); end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(2, 1'b0, 1'b0, 32'h0, 32'h0);
    rd_m[0] = 32'h0; rd_m[1] = 32'h0;
    repeat (3) @(negedge clk);
    test_reset;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_write_read;
    test_misaligned;
    test_held;
    test_drop;
    test_reset_mid_wait;
    test_random;
    test_wait0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_resp.md
MEM_RESP -- requirements
Module: mem_resp

Interface
REQ-001 Parameter ADDR_W, default 8: word-address width; memory depth 2^ADDR_W 32-bit words.
REQ-002 Parameter WAIT_CYC, default 2, legal range 0..15: wait cycles inserted before each response.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 MemRd  input  1  read request level from control unit.
REQ-006 MemWr  input  1  write request level from control unit.
REQ-007 Addr  input  32  byte address (PC or ALUOut, selected upstream by IorD).
REQ-008 WrData  input  32  write data (register B).
REQ-009 RdData  output  32  read data to IR/MDR, registered.
REQ-010 MemRdy  output  1  one-cycle completion pulse.
REQ-011 MemErr  output  1  one-cycle error pulse, coincident with MemRdy.
REQ-012 Busy  output  1  high while a request is in progress (states WAIT and RESP).

Function
REQ-013 FSM states SHALL be IDLE, WAIT, RESP, HOLD; encoding free.
REQ-014 IDLE: if MemRd|MemWr, SHALL capture Addr, WrData, request type and error flag into registers; go to WAIT if WAIT_CYC>0, else RESP.
REQ-015 WAIT: down-counter loaded with WAIT_CYC-1 on capture; decrement each cycle; at 0 go to RESP.
REQ-016 RESP: SHALL assert MemRdy for exactly this cycle; perform access; go to HOLD.
REQ-017 HOLD: SHALL wait until MemRd=0 and MemWr=0, then go to IDLE; prevents a held request from double-issuing; a request high in the same cycle as HOLD exit is not accepted until the next IDLE cycle.
REQ-018 Latency: request first seen high in cycle N -> MemRdy high in cycle N+1+WAIT_CYC.
REQ-019 Read: RdData SHALL update in the RESP cycle with mem[Addr[ADDR_W+1:2]] and hold until the next successful read completes.
REQ-020 Write: mem[Addr[ADDR_W+1:2]] <= WrData at the RESP edge; RdData unchanged.
REQ-021 Error: set at capture if Addr[1:0]!=0, Addr[31:ADDR_W+2]!=0, or MemRd&MemWr both high; errored request SHALL NOT write memory or change RdData; MemErr=1 with MemRdy.
REQ-022 Inputs are sampled only at capture; changes to Addr/WrData/MemRd/MemWr during WAIT/RESP SHALL be ignored; a request dropped mid-WAIT still completes (write committed, MemRdy pulses).
REQ-023 Memory is word-only; no byte enables; read-after-write to same address returns the new data.

Reset
REQ-024 rst_n low SHALL immediately force state IDLE, counter 0, RdData=0, MemRdy=0, MemErr=0, Busy=0.
REQ-025 Reset mid-WAIT SHALL abort the pending access: no memory write, no MemRdy.
REQ-026 Memory contents are not reset; initial contents loadable by simulation preload only.

Verification
REQ-027 WAIT_CYC=2: write 0xDEADBEEF to 0x10 (MemWr held) -> MemRdy one pulse 3 cycles after request; then read 0x10 -> RdData=0xDEADBEEF at MemRdy, MemErr=0.
REQ-028 Read Addr=0x00000013 -> MemRdy and MemErr both 1 for one cycle, RdData keeps previous value.
REQ-029 MemRd held high 10 cycles -> exactly one MemRdy pulse; drop MemRd, raise again -> second pulse.
REQ-030 Write to 0x20, drop MemWr after 1 cycle -> MemRdy still pulses; later read of 0x20 returns written data.
REQ-031 Assert rst_n=0 during WAIT of write to 0x30 -> no MemRdy; read 0x30 afterwards returns preloaded value; RdData=0 right after reset.
REQ-032 WAIT_CYC=0 build: read request cycle N -> MemRdy cycle N+1; MemRd&MemWr both high -> MemErr=1, memory unchanged.
